// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: PC-unit redirect, instruction memory port and decode handshake.
interface ifu_fetch_if
    import mips_fetch_pkg::*;
;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue with registered head entry and head-valid flag.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   valid_o,
    output fetch_entry_t           head_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    fetch_entry_t     head_q, head_d;
    logic             pop_ok, push_ok;

    // Pointer/count update and look-ahead of the entry that becomes head.
    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
        valid_d = (count_d != '0);
        head_d  = head_q;
        if (valid_d) begin
            head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
        end
    end

    // Control and head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are meaningless until counted in.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;
    assign head_o  = head_q;
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: sequential pointer, single outstanding imem read, prefetch queue.
module ifu_fetch
    import mips_fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    ifu_fetch_if.master  fetch_if
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_c, push_c, pop_c, full_c;
    logic [CNT_W-1:0] count;
    logic            head_valid;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign full_c     = (count == CNT_W'(DEPTH));
    assign pop_c      = head_valid && fetch_if.inst_ready;
    assign push_entry = '{pc: req_pc_q, inst: fetch_if.imem_rdata};

    // Next-state, request issue and push decision.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_c      = 1'b0;
        push_c     = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (!fetch_if.redirect_valid && !full_c) begin
                    req_c      = 1'b1;
                    state_d    = FETCH_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + INST_BYTES;
                end
            end
            FETCH_WAIT: begin
                if (fetch_if.imem_rvalid) begin
                    state_d = FETCH_IDLE;
                    push_c  = !fetch_if.redirect_valid;
                end else if (fetch_if.redirect_valid) begin
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (fetch_if.imem_rvalid) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
        if (fetch_if.redirect_valid) begin
            fetch_pc_d = align_word(fetch_if.redirect_pc);
        end
    end

    // State and fetch pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push_c),
        .push_data_i(push_entry),
        .pop_i      (pop_c),
        .flush_i    (fetch_if.redirect_valid),
        .count_o    (count),
        .valid_o    (head_valid),
        .head_o     (head)
    );

    assign fetch_if.imem_req   = req_c && !reset;
    assign fetch_if.imem_addr  = (state_q == FETCH_IDLE) ? fetch_pc_q : req_pc_q;
    assign fetch_if.inst_valid = head_valid;
    assign fetch_if.inst_data  = head.inst;
    assign fetch_if.inst_pc    = head.pc;
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus randomized traffic against a queue model.
module tb_ifu_fetch;
    import mips_fetch_pkg::*;

    localparam int DEPTH_A = 2;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_if bus_a ();
    ifu_fetch_if bus_b ();

    ifu_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) u_dut_a (
        .clk(clk), .reset(reset_a), .fetch_if(bus_a));
    ifu_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_b (
        .clk(clk), .reset(reset_b), .fetch_if(bus_b));

    int checks = 0;
    int errors = 0;
    bit b_done = 1'b0;

    // Stimulus controls for DUT A
    logic        rst_drv = 1'b1;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        rdy = 1'b0;
    int          lat = 1;
    bit          rand_lat = 1'b0;

    // Memory responder state
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic        resp;

    // Reference model
    fetch_entry_t m_q[$];
    logic [31:0]  m_fetch = '0;
    logic [31:0]  m_req_pc = '0;
    bit           m_out = 1'b0;
    bit           m_stale = 1'b0;

    // Observations and logs
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_data;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];
    logic [31:0] req_addr_log[$];
    bit          req_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of DUT A: drive, compare against model, then advance model.
    task automatic step();
        logic        exp_req;
        logic [31:0] exp_addr;
        fetch_entry_t e;
        exp_req = 1'b0;
        @(negedge clk);
        reset_a = rst_drv;
        resp = !rst_drv && mem_busy && (mem_cnt == 1);
        bus_a.redirect_valid = redir;
        bus_a.redirect_pc    = redir_pc;
        bus_a.inst_ready     = rdy;
        bus_a.imem_rvalid    = resp;
        bus_a.imem_rdata     = resp ? (mem_addr ^ 32'hA5A5_0000) : $urandom;
        #1;
        obs_req   = bus_a.imem_req;
        obs_addr  = bus_a.imem_addr;
        obs_valid = bus_a.inst_valid;
        obs_pc    = bus_a.inst_pc;
        obs_data  = bus_a.inst_data;
        if (rst_drv) begin
            chk("rst_imem_req", 32'(obs_req), 32'd0);
            chk("rst_imem_addr", obs_addr, 32'h0);
            chk("rst_inst_valid", 32'(obs_valid), 32'd0);
            chk("rst_inst_data", obs_data, 32'h0);
            chk("rst_inst_pc", obs_pc, 32'h0);
        end else begin
            exp_req = !m_out && !redir && (m_q.size() < DEPTH_A);
            chk("imem_req", 32'(obs_req), 32'(exp_req));
            if (m_out || exp_req) begin
                exp_addr = m_out ? m_req_pc : m_fetch;
                chk("imem_addr", obs_addr, exp_addr);
            end
            chk("inst_valid", 32'(obs_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("inst_pc", obs_pc, m_q[0].pc);
                chk("inst_data", obs_data, m_q[0].inst);
            end
            if (obs_valid && rdy) begin
                pop_pc.push_back(obs_pc);
                pop_data.push_back(obs_data);
            end
        end
        @(posedge clk);
        if (rst_drv) begin
            m_q.delete();
            m_fetch = 32'h0;
            m_req_pc = 32'h0;
            m_out = 1'b0;
            m_stale = 1'b0;
        end else begin
            if (m_q.size() != 0 && rdy) m_q.delete(0);
            if (redir) begin
                m_q.delete();
                m_fetch = redir_pc & 32'hFFFF_FFFC;
                if (m_out && resp) begin
                    m_out = 1'b0;
                    m_stale = 1'b0;
                end else if (m_out) begin
                    m_stale = 1'b1;
                end
            end else if (exp_req) begin
                m_out = 1'b1;
                m_stale = 1'b0;
                m_req_pc = m_fetch;
                m_fetch = m_fetch + 32'd4;
            end else if (m_out && resp) begin
                if (!m_stale) begin
                    e.pc = m_req_pc;
                    e.inst = bus_a.imem_rdata;
                    m_q.push_back(e);
                end
                m_out = 1'b0;
                m_stale = 1'b0;
            end
        end
        if (rst_drv || resp) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (!rst_drv && obs_req) begin
            mem_busy = 1'b1;
            mem_cnt  = rand_lat ? int'($urandom_range(3, 1)) : lat;
            mem_addr = obs_addr;
        end
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        redir = 1'b0;
        step();
        rst_drv = 1'b0;
    endtask

    // DUT A scenarios
    initial begin : proc_a
        bit          got_req, got_valid;
        logic [31:0] first_addr, first_pc, first_data;
        int          nreq;

        rst_drv = 1'b1;
        repeat (2) step();
        rst_drv = 1'b0;

        // Sequential fetch, 1-cycle memory, decode always ready
        rdy = 1'b1; lat = 1;
        pop_pc.delete(); pop_data.delete(); req_log.delete();
        for (int k = 0; k < 10; k++) begin
            step();
            req_log.push_back(obs_req);
        end
        for (int k = 0; k < 8; k++) chk("seq_req_pulse", 32'(req_log[k]), 32'((k % 2) == 0));
        chk("seq_pop_count", 32'(pop_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_pc.size()) begin
                chk("seq_inst_pc", pop_pc[i], 32'(i * 4));
                chk("seq_inst_data", pop_data[i], 32'(i * 4) ^ 32'hA5A5_0000);
            end
        end

        // Backpressure fills the two-entry queue
        do_reset();
        rdy = 1'b0; lat = 1; req_addr_log.delete();
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_req) req_addr_log.push_back(obs_addr);
        end
        chk("bp_req_count", 32'(req_addr_log.size()), 32'd2);
        if (req_addr_log.size() >= 2) begin
            chk("bp_addr0", req_addr_log[0], 32'h0);
            chk("bp_addr1", req_addr_log[1], 32'h4);
        end
        rdy = 1'b1;
        step();
        chk("bp_pop_valid", 32'(obs_valid), 32'd1);
        chk("bp_pop_pc", obs_pc, 32'h0);
        chk("bp_full_no_req", 32'(obs_req), 32'd0);
        step();
        chk("bp_resume_req", 32'(obs_req), 32'd1);
        chk("bp_resume_addr", obs_addr, 32'h8);

        // Redirect while a 3-cycle read is outstanding
        do_reset();
        rdy = 1'b1; lat = 3;
        step();
        step();
        redir = 1'b1; redir_pc = 32'h0000_0103;
        step();
        redir = 1'b0;
        got_req = 1'b0; got_valid = 1'b0;
        first_addr = '0; first_pc = '0; first_data = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (obs_req && !got_req) begin got_req = 1'b1; first_addr = obs_addr; end
            if (obs_valid && !got_valid) begin
                got_valid = 1'b1; first_pc = obs_pc; first_data = obs_data;
            end
        end
        chk("rd_first_addr", first_addr, 32'h0000_0100);
        chk("rd_first_pc", first_pc, 32'h0000_0100);
        chk("rd_first_data", first_data, 32'h0000_0100 ^ 32'hA5A5_0000);

        // Redirect coinciding with the response
        do_reset();
        rdy = 1'b1; lat = 2;
        step();
        step();
        redir = 1'b1; redir_pc = 32'h0000_0200;
        step();
        redir = 1'b0;
        step();
        chk("same_req", 32'(obs_req), 32'd1);
        chk("same_addr", obs_addr, 32'h0000_0200);
        chk("same_not_pushed", 32'(obs_valid), 32'd0);
        step();
        step();
        step();
        chk("same_new_valid", 32'(obs_valid), 32'd1);
        chk("same_new_pc", obs_pc, 32'h0000_0200);

        // Randomized traffic
        do_reset();
        rand_lat = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(499, 0) == 0) begin
                do_reset();
            end else begin
                rdy = ($urandom_range(3, 0) != 0);
                redir = ($urandom_range(11, 0) == 0);
                redir_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                       : 32'($urandom);
                step();
            end
        end

        nreq = 0;
        while (!b_done && nreq < 100) begin
            @(posedge clk);
            nreq++;
        end
        chk("b_finished", 32'(b_done), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // DUT B: wrap-around from the top of memory and reset with work in flight
    initial begin : proc_b
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = '0;
        bus_b.imem_rvalid    = 1'b0;
        bus_b.imem_rdata     = '0;
        bus_b.inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
        #1;
        chk("b_req0", 32'(bus_b.imem_req), 32'd1);
        chk("b_addr0", bus_b.imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 32'h1111_0000;
        #1;
        chk("b_req_wait", 32'(bus_b.imem_req), 32'd0);
        @(negedge clk);
        bus_b.imem_rvalid = 1'b0;
        #1;
        chk("b_req1", 32'(bus_b.imem_req), 32'd1);
        chk("b_addr1", bus_b.imem_addr, 32'hFFFF_FFFC);
        chk("b_valid1", 32'(bus_b.inst_valid), 32'd1);
        chk("b_pc1", bus_b.inst_pc, 32'hFFFF_FFF8);
        chk("b_data1", bus_b.inst_data, 32'h1111_0000);
        @(negedge clk);
        bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 32'h2222_0000;
        @(negedge clk);
        bus_b.imem_rvalid = 1'b0;
        #1;
        chk("b_req2", 32'(bus_b.imem_req), 32'd1);
        chk("b_addr_wrap", bus_b.imem_addr, 32'h0000_0000);
        @(negedge clk);
        #1;
        chk("b_outstanding", 32'(bus_b.imem_req), 32'd0);
        chk("b_head_kept", bus_b.inst_pc, 32'hFFFF_FFF8);
        reset_b = 1'b1;
        #1;
        chk("b_rst_valid", 32'(bus_b.inst_valid), 32'd0);
        chk("b_rst_pc", bus_b.inst_pc, 32'h0);
        chk("b_rst_data", bus_b.inst_data, 32'h0);
        chk("b_rst_req", 32'(bus_b.imem_req), 32'd0);
        chk("b_rst_addr", bus_b.imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        reset_b = 1'b0;
        bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 32'h3333_0000;
        #1;
        chk("b_post_req", 32'(bus_b.imem_req), 32'd1);
        chk("b_post_addr", bus_b.imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        bus_b.imem_rvalid = 1'b0;
        #1;
        chk("b_late_ignored", 32'(bus_b.inst_valid), 32'd0);
        chk("b_post_wait", 32'(bus_b.imem_req), 32'd0);
        @(negedge clk);
        bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 32'h4444_0000;
        @(negedge clk);
        bus_b.imem_rvalid = 1'b0;
        #1;
        chk("b_new_valid", 32'(bus_b.inst_valid), 32'd1);
        chk("b_new_pc", bus_b.inst_pc, 32'hFFFF_FFF8);
        chk("b_new_data", bus_b.inst_data, 32'h4444_0000);
        b_done = 1'b1;
    end
endmodule
